seq_mul_param: RTL

Parametrised sequential shift-add multiplier, successor to the fixed 4x4 unsigned sequential multiplier.
- Generalised to WIDTH-bit operands.
- Adds a signed/unsigned mode, synchronous reset, explicit busy/done handshake, and a held result register.
- Sits behind the Tiny Tapeout top wrapper as the arithmetic core; the wrapper maps pins to a/b/start/signed_mode.

---
 rtl/seq_mul_param_pkg.sv | 11 +
 rtl/seq_mul_param_if.sv | 35 +++
 rtl/seq_mul_param_iter_cnt.sv | 26 ++
 rtl/seq_mul_param.sv | 103 ++++++++++
 4 files changed

// File: rtl/seq_mul_param_pkg.sv
// Shared constants for the parametrised sequential multiplier.
// State encoding and the operand width ceiling.
package seq_mul_param_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MAX_WIDTH = 16;

endpackage

// File: rtl/seq_mul_param_if.sv
// Request/result bundle between the wrapper and the multiplier core.
// The master issues operands; the slave reports busy/done and the product.
interface seq_mul_param_if #(
    parameter int WIDTH = 8
);

    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   op;

    modport master (
        output start,
        output signed_mode,
        output a,
        output b,
        input  busy,
        input  done,
        input  op
    );

    modport slave (
        input  start,
        input  signed_mode,
        input  a,
        input  b,
        output busy,
        output done,
        output op
    );

endinterface

// File: rtl/seq_mul_param_iter_cnt.sv
// Iteration counter for the shift-add loop.
// Flags the final iteration so the FSM can leave RUN on that edge.
module seq_mul_iter_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_mul_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed mode multiplies magnitudes and negates the product at the end.
import seq_mul_param_pkg::*;

module seq_mul_param #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    seq_mul_param_if.slave bus
);

    generate
        if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("seq_mul_param: WIDTH must be 2..16");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_op;

    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;

    assign w_run    = (r_state == ST_RUN);
    assign w_accept = bus.start &&
                      (r_state == ST_IDLE || r_state == ST_DONE);

    always_comb begin
        w_a_neg = bus.signed_mode & bus.a[WIDTH-1];
        w_b_neg = bus.signed_mode & bus.b[WIDTH-1];
        w_a_mag = w_a_neg ? (~bus.a + 1'b1) : bus.a;
        w_b_mag = w_b_neg ? (~bus.b + 1'b1) : bus.b;
        w_sum   = r_acc +
                  ({(WIDTH + 1){r_mplier[0]}} & {1'b0, r_mcand});
        // Product as it stands after this iteration's shift.
        w_prod  = {w_sum, r_mplier[WIDTH-1:1]};
    end

    seq_mul_iter_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_accept),
        .i_en   (w_run),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_op     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_state  <= ST_RUN;
                        r_acc    <= '0;
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_neg    <= w_a_neg ^ w_b_neg;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc    <= {1'b0, w_sum[WIDTH:1]};
                    r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_op    <= r_neg ? -w_prod : w_prod;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = w_run;
    assign bus.done = (r_state == ST_DONE);
    assign bus.op   = r_op;

endmodule
